// File: rtl/ahb_sram_pkg.sv
// Shared encodings and types for the AHB-Lite to DFFRAM bridge.
package ahb_sram_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dp_state_e;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Byte-lane decode: HSIZE and low address bits to a write mask plus a misalignment flag.
module ahb_sram_lane_dec
  import ahb_sram_pkg::*;
(
  input  logic [2:0]           hsize,
  input  logic [1:0]           addr_lo,
  output logic [NUM_LANES-1:0] mask,
  output logic                 misaligned
);

  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = NUM_LANES'(1) << addr_lo;
      HSIZE_HALF: begin
        mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask       = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default:    misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave in front of a single-port DFFRAM: zero-wait reads, one-entry
// posted write buffer with read-after-write forwarding, two-cycle ERROR on misalignment.
module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [DW-1:0]        HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [DW-1:0]        HRDATA,
  input  logic [DW-1:0]        SRAMRDATA,
  output logic                 SRAMCS,
  output logic [NUM_LANES-1:0] SRAMWEN,
  output logic [DW-1:0]        SRAMWDATA,
  output logic [AW-1:0]        SRAMADDR
);

  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  logic [AW-1:0]        hw_addr;
  logic [NUM_LANES-1:0] dec_mask;
  logic                 dec_mis;
  logic                 valid, rd_ap, wr_ap, err_ap, commit;
  logic [DW-1:0]        rd_merge;

  dp_state_e            state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 wdp_q, wdp_d;
  logic                 rdp_q, rdp_d;
  logic [AW-1:0]        buf_addr_q, buf_addr_d;
  logic [NUM_LANES-1:0] buf_mask_q, buf_mask_d;
  logic [DW-1:0]        buf_data_q, buf_data_d;
  logic [NUM_LANES-1:0] fwd_mask_q, fwd_mask_d;
  logic [DW-1:0]        hrdata_q, hrdata_d;

  assign hw_addr = HADDR[AW+1:2];

  ahb_sram_lane_dec u_lane_dec (
    .hsize      (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .mask       (dec_mask),
    .misaligned (dec_mis)
  );

  // Reset gates the strobes so nothing reaches the SRAM while HRESETn is low.
  assign valid  = HRESETn & HSEL & HTRANS[1] & HREADY;
  assign rd_ap  = valid & ~HWRITE & ~dec_mis;
  assign wr_ap  = valid &  HWRITE & ~dec_mis;
  assign err_ap = valid &  dec_mis;

  // A new write evicts the old entry at once; otherwise drain only when the
  // SRAM port is free and the entry's data has already been captured.
  assign commit = HRESETn & pend_q & (wr_ap | (~rd_ap & ~wdp_q));

  always_comb begin
    rd_merge = SRAMRDATA;
    for (int i = 0; i < NUM_LANES; i++)
      if (fwd_mask_q[i]) rd_merge[8*i +: 8] = buf_data_q[8*i +: 8];
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wdp_d      = wr_ap;
    rdp_d      = rd_ap;
    buf_addr_d = buf_addr_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    fwd_mask_d = fwd_mask_q;
    hrdata_d   = hrdata_q;

    case (state_q)
      ST_OKAY: if (err_ap) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = err_ap ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase

    if (wdp_q) buf_data_d = HWDATA;

    if (wr_ap) begin
      buf_addr_d = hw_addr;
      buf_mask_d = dec_mask;
      pend_d     = 1'b1;
    end else if (commit) begin
      pend_d = 1'b0;
    end

    if (rd_ap)
      fwd_mask_d = (pend_q && (buf_addr_q == hw_addr)) ? buf_mask_q : '0;

    if (rdp_q) hrdata_d = rd_merge;
  end

  always_comb begin
    HREADYOUT = (state_q != ST_ERR1);
    HRESP     = (state_q == ST_OKAY) ? HRESP_OKAY : HRESP_ERROR;
    HRDATA    = rdp_q ? rd_merge : hrdata_q;

    SRAMCS    = 1'b0;
    SRAMWEN   = '0;
    SRAMADDR  = hw_addr;
    SRAMWDATA = buf_data_q;
    if (rd_ap) begin
      SRAMCS = 1'b1;
    end else if (commit) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = buf_mask_q;
      SRAMADDR  = buf_addr_q;
      // Eviction during the entry's own data phase takes the bus data directly.
      SRAMWDATA = wdp_q ? HWDATA : buf_data_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_OKAY;
      pend_q     <= 1'b0;
      wdp_q      <= 1'b0;
      rdp_q      <= 1'b0;
      buf_addr_q <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
      fwd_mask_q <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wdp_q      <= wdp_d;
      rdp_q      <= rdp_d;
      buf_addr_q <= buf_addr_d;
      buf_mask_q <= buf_mask_d;
      buf_data_q <= buf_data_d;
      fwd_mask_q <= fwd_mask_d;
      hrdata_q   <= hrdata_d;
    end
  end

endmodule
